// File: rtl/ov5640_cfg_seq.sv
// OV5640 bring-up sequencer: power-up pin phases, then walks a register table over SCCB
// with per-entry retries and 0xFFFF delay markers; enables capture when the table completes.
module ov5640_cfg_seq #(
   parameter int TABLE_LEN  = 250,
   parameter int PWRUP_DLY  = 1_000_000,
   parameter int DELAY_UNIT = 50_000,
   parameter int MAX_RETRY  = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic [7:0]  tbl_addr_o,
   input  logic [23:0] tbl_data_i,
   output logic        sccb_req_o,
   output logic [15:0] sccb_addr_o,
   output logic [7:0]  sccb_data_o,
   input  logic        sccb_done_i,
   input  logic        sccb_nack_i,
   output logic        cmos_pwdn_o,
   output logic        cmos_rst_n_o,
   output logic        cfg_busy_o,
   output logic        cfg_done_o,
   output logic        cfg_err_o,
   output logic        cap_en_o,
   output logic [3:0]  dbg_state_o
);

   // SCCB handshake: sccb_req_o rises with a stable addr/data and stays high until the
   // single-cycle sccb_done_i pulse is sampled; sccb_nack_i is only meaningful with done.
   typedef enum logic [3:0] {
      S_IDLE, S_PWR0, S_PWR1, S_PWR2, S_FETCH, S_LATCH,
      S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERR
   } state_t;

   localparam int DLY_MAX = 255 * DELAY_UNIT;
   localparam int CNT_MAX = (PWRUP_DLY > DLY_MAX) ? PWRUP_DLY : DLY_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWRUP_DLY - 1);
   localparam logic [CNT_W-1:0] DU_C     = CNT_W'(DELAY_UNIT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [RW-1:0]    RT_LAST  = RW'(MAX_RETRY - 1);
   localparam logic [RW-1:0]    RT_ONE   = RW'(1);
   localparam logic [7:0]       LAST_IDX = 8'(TABLE_LEN - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [RW-1:0]     retry;
   logic [7:0]        idx;
   logic [23:0]       word_q;

   assign dbg_state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         cnt          <= '0;
         retry        <= '0;
         idx          <= '0;
         word_q       <= '0;
         tbl_addr_o   <= '0;
         sccb_req_o   <= 1'b0;
         sccb_addr_o  <= '0;
         sccb_data_o  <= '0;
         cmos_pwdn_o  <= 1'b1;
         cmos_rst_n_o <= 1'b0;
         cfg_busy_o   <= 1'b0;
         cfg_done_o   <= 1'b0;
         cfg_err_o    <= 1'b0;
         cap_en_o     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start_i) begin
                  state        <= S_PWR0;
                  cnt          <= PWR_LOAD;
                  cmos_pwdn_o  <= 1'b1;
                  cmos_rst_n_o <= 1'b0;
                  cfg_busy_o   <= 1'b1;
                  cfg_done_o   <= 1'b0;
                  cfg_err_o    <= 1'b0;
                  cap_en_o     <= 1'b0;
               end
            end
            S_PWR0: begin
               if (cnt == '0) begin
                  state       <= S_PWR1;
                  cnt         <= PWR_LOAD;
                  cmos_pwdn_o <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_PWR1: begin
               if (cnt == '0) begin
                  state        <= S_PWR2;
                  cnt          <= PWR_LOAD;
                  cmos_rst_n_o <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_PWR2: begin
               if (cnt == '0) begin
                  state      <= S_FETCH;
                  idx        <= '0;
                  retry      <= '0;
                  tbl_addr_o <= '0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_FETCH: state <= S_LATCH;
            S_LATCH: begin
               word_q <= tbl_data_i;
               // Address 0xFFFF is a delay marker; its data byte counts DELAY_UNIT blocks.
               if (tbl_data_i[23:8] == 16'hFFFF) begin
                  state <= S_DELAY;
                  cnt   <= CNT_W'(tbl_data_i[7:0]) * DU_C;
               end else begin
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               sccb_req_o  <= 1'b1;
               sccb_addr_o <= word_q[23:8];
               sccb_data_o <= word_q[7:0];
               state       <= S_WAIT;
            end
            S_WAIT: begin
               if (sccb_done_i) begin
                  sccb_req_o <= 1'b0;
                  if (!sccb_nack_i) begin
                     state <= S_NEXT;
                  end else begin
                     retry <= retry + RT_ONE;
                     if (retry < RT_LAST) begin
                        state <= S_ISSUE;
                     end else begin
                        state      <= S_ERR;
                        cfg_busy_o <= 1'b0;
                        cfg_err_o  <= 1'b1;
                     end
                  end
               end
            end
            // Leaving at cnt<=1 gives exactly N cycles for N>0 and one cycle for N=0.
            S_DELAY: begin
               if (cnt <= CNT_ONE) state <= S_NEXT;
               else                cnt   <= cnt - CNT_ONE;
            end
            S_NEXT: begin
               retry <= '0;
               if (idx == LAST_IDX) begin
                  state      <= S_DONE;
                  cfg_busy_o <= 1'b0;
                  cfg_done_o <= 1'b1;
                  cap_en_o   <= 1'b1;
               end else begin
                  idx        <= idx + 8'd1;
                  tbl_addr_o <= idx + 8'd1;
                  state      <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Directed bench for ov5640_cfg_seq: ROM and SCCB models, a write scoreboard fed at
// stimulus time and drained by a monitor on each sccb_req_o rise.
module tb_ov5640_cfg_seq;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_PWR0  = 4'd1;
   localparam logic [3:0] ST_DELAY = 4'd8;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start;
   logic [7:0]  tbl_addr;
   logic [23:0] tbl_data;
   logic        sccb_req, sccb_done, sccb_nack;
   logic [15:0] sccb_addr;
   logic [7:0]  sccb_data;
   logic        pwdn, rst_n, busy, done, err, cap_en;
   logic [3:0]  dbg_state;

   ov5640_cfg_seq #(
      .TABLE_LEN(4), .PWRUP_DLY(10), .DELAY_UNIT(5), .MAX_RETRY(2)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
      .sccb_req_o(sccb_req), .sccb_addr_o(sccb_addr), .sccb_data_o(sccb_data),
      .sccb_done_i(sccb_done), .sccb_nack_i(sccb_nack),
      .cmos_pwdn_o(pwdn), .cmos_rst_n_o(rst_n),
      .cfg_busy_o(busy), .cfg_done_o(done), .cfg_err_o(err), .cap_en_o(cap_en),
      .dbg_state_o(dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;
   int writes = 0;
   int delay_cyc = 0;
   int nack_left = 0;
   logic [23:0] rom [4];
   logic [23:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, expv);
      end
   endtask

   // ROM model: data for tbl_addr is presented within the same cycle the address is held
   initial begin
      tbl_data = '0;
      forever begin
         @(negedge clk);
         tbl_data = rom[tbl_addr[1:0]];
      end
   end

   // SCCB model: done pulse 8 cycles after req rises; NACKs writes to 0x3103 while nack_left>0
   initial begin
      int age;
      age = 0;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      forever begin
         @(negedge clk);
         sccb_done = 1'b0;
         sccb_nack = 1'b0;
         if (sccb_req) begin
            age++;
            if (age == 8) begin
               sccb_done = 1'b1;
               if (sccb_addr == 16'h3103 && nack_left > 0) begin
                  sccb_nack = 1'b1;
                  nack_left--;
               end
            end
         end else begin
            age = 0;
         end
      end
   end

   // scoreboard monitor
   initial begin
      logic prev_req;
      logic [23:0] e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (dbg_state == ST_DELAY) delay_cyc++;
         if (sccb_req && !prev_req) begin
            writes++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got %h required none", {sccb_addr, sccb_data});
            end else begin
               e = exp_q.pop_front();
               check("write", {8'h0, sccb_addr, sccb_data}, {8'h0, e});
            end
         end
         prev_req = sccb_req;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic check_reset_vals();
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_tbl_addr", tbl_addr, 0);
      check("rst_req", sccb_req, 0);
      check("rst_addr", sccb_addr, 0);
      check("rst_data", sccb_data, 0);
      check("rst_pwdn", pwdn, 1);
      check("rst_rst_n", rst_n, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cap_en", cap_en, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      exp_q.delete();
      writes = 0;
      delay_cyc = 0;
      rst = 1'b0;
   endtask

   task automatic set_table(input logic [7:0] marker_data);
      rom[0] = 24'h3008_82;
      rom[1] = 24'h3103_02;
      rom[2] = {16'hFFFF, marker_data};
      rom[3] = 24'h4300_61;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Measures pin phases from the first PWR0 cycle up to the first sccb_req_o
   task automatic run_phases(input bit poke_pwr1);
      int n;
      n = 0;
      while (pins() == 2'b10 && n < 100) begin n++; @(negedge clk); end
      check("pwr0_cycles", n, 10);
      n = 0;
      while (pins() == 2'b00 && n < 100) begin
         n++;
         if (poke_pwr1 && n == 3) start = 1'b1;
         if (poke_pwr1 && n == 5) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      check("pwr1_cycles", n, 10);
      n = 0;
      while (!sccb_req && n < 100) begin n++; @(negedge clk); end
      check("pwr2_to_req_cycles", n, 13);
      check("pins_at_req", pins(), 2'b01);
   endtask

   function automatic logic [1:0] pins();
      return {pwdn, rst_n};
   endfunction

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (!(done || err) && n < 3000) begin @(negedge clk); n++; end
      check(name, (n < 3000) ? 1 : 0, 1);
   endtask

   task automatic push_std();
      exp_q.push_back(24'h3008_82);
      exp_q.push_back(24'h3103_02);
      exp_q.push_back(24'h4300_61);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      set_table(8'h02);

      // power-up phases, plain table, marker delay
      do_reset();
      push_std();
      pulse_start();
      check("busy_in_pwr0", busy, 1);
      run_phases(1'b0);
      wait_end("s1_end_reached");
      check("s1_done", done, 1);
      check("s1_cap_en", cap_en, 1);
      check("s1_busy", busy, 0);
      check("s1_err", err, 0);
      check("s1_writes", writes, 3);
      check("s1_delay_cycles", delay_cyc, 10);
      check("s1_queue_left", exp_q.size(), 0);

      // single NACK on entry 1, zero-length marker
      do_reset();
      set_table(8'h00);
      nack_left = 1;
      exp_q.push_back(24'h3008_82);
      exp_q.push_back(24'h3103_02);
      exp_q.push_back(24'h3103_02);
      exp_q.push_back(24'h4300_61);
      pulse_start();
      wait_end("s2_end_reached");
      check("s2_done", done, 1);
      check("s2_err", err, 0);
      check("s2_writes", writes, 4);
      check("s2_delay_cycles", delay_cyc, 1);
      check("s2_queue_left", exp_q.size(), 0);

      // two NACKs on entry 1 exhaust retries
      do_reset();
      set_table(8'h02);
      nack_left = 2;
      exp_q.push_back(24'h3008_82);
      exp_q.push_back(24'h3103_02);
      exp_q.push_back(24'h3103_02);
      pulse_start();
      wait_end("s3_end_reached");
      repeat (60) @(negedge clk);
      check("s3_err", err, 1);
      check("s3_cap_en", cap_en, 0);
      check("s3_done", done, 0);
      check("s3_busy", busy, 0);
      check("s3_pins", pins(), 2'b01);
      check("s3_writes", writes, 3);
      check("s3_queue_left", exp_q.size(), 0);

      // reset during WAIT with start held high
      do_reset();
      nack_left = 0;
      exp_q.push_back(24'h3008_82);
      pulse_start();
      n = 0;
      while (!sccb_req && n < 200) begin n++; @(negedge clk); end
      check("s4_reached_wait", sccb_req, 1);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check_reset_vals();
      @(negedge clk);
      push_std();
      rst = 1'b0;
      @(negedge clk);
      check("s4_restart_state", dbg_state, ST_PWR0);
      check("s4_restart_pins", pins(), 2'b10);
      check("s4_restart_busy", busy, 1);
      start = 1'b0;
      wait_end("s4_end_reached");
      check("s4_done", done, 1);
      check("s4_writes", writes, 4);
      check("s4_queue_left", exp_q.size(), 0);

      // restart from DONE, start pokes during PWR1 ignored
      writes = 0;
      delay_cyc = 0;
      push_std();
      pulse_start();
      check("s5_done_cleared", done, 0);
      check("s5_cap_cleared", cap_en, 0);
      check("s5_busy", busy, 1);
      check("s5_state", dbg_state, ST_PWR0);
      run_phases(1'b1);
      wait_end("s5_end_reached");
      check("s5_done", done, 1);
      check("s5_cap_en", cap_en, 1);
      check("s5_writes", writes, 3);
      check("s5_delay_cycles", delay_cyc, 10);
      check("s5_queue_left", exp_q.size(), 0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
